// File: rtl/serial_frame_tx.sv
// Parallel-to-serial framer. Each accepted word goes out on ser_out as a start
// bit (0), the data MSB-first, an optional even-parity bit, and a stop bit (1).
// Every bit is held for DIV clocks. shift_en strobes on the first clock of each
// bit to clock the downstream shift chain.
module serial_frame_tx #(
  parameter int DATA_W    = 16,
  parameter int DIV       = 4,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ser_out,
  output logic              shift_en,
  output logic              busy,
  output logic              frame_done
);

  if (DIV < 1) begin : g_bad_div
    $error("serial_frame_tx: DIV must be >= 1");
  end
  if (DATA_W < 1 || DATA_W > 32) begin : g_bad_width
    $error("serial_frame_tx: DATA_W must be in 1..32");
  end

  localparam int DIV_CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [DIV_CW-1:0] DIV_LAST = DIV_CW'(DIV - 1);
  localparam logic [BIT_CW-1:0] BIT_LAST = BIT_CW'(DATA_W - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [DIV_CW-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              ser_out_q, ser_out_d;
  logic              s_ready_q, s_ready_d;
  logic              shift_en_q, shift_en_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              bit_end;

  // Last clock of the current bit period.
  assign bit_end = (div_cnt_q == DIV_LAST);

  // Next-state logic: bit timing, frame sequencing and output updates.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    ser_out_d    = ser_out_q;
    s_ready_d    = s_ready_q;
    shift_en_d   = 1'b0;
    busy_d       = busy_q;
    frame_done_d = 1'b0;

    if (state_q != ST_IDLE) begin
      div_cnt_d = bit_end ? '0 : div_cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (s_valid && s_ready_q) begin
          shift_d    = s_data;
          parity_d   = ^s_data;
          div_cnt_d  = '0;
          bit_cnt_d  = '0;
          state_d    = ST_START;
          s_ready_d  = 1'b0;
          busy_d     = 1'b1;
          ser_out_d  = 1'b0;
          shift_en_d = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          // shift_q always holds the next data bit in its MSB.
          state_d    = ST_DATA;
          bit_cnt_d  = '0;
          ser_out_d  = shift_q[DATA_W-1];
          shift_d    = shift_q << 1;
          shift_en_d = 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_en_d = 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            state_d   = PARITY_EN ? ST_PARITY : ST_STOP;
            ser_out_d = PARITY_EN ? parity_q : 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            ser_out_d = shift_q[DATA_W-1];
            shift_d   = shift_q << 1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d    = ST_STOP;
          ser_out_d  = 1'b1;
          shift_en_d = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          state_d      = ST_IDLE;
          busy_d       = 1'b0;
          s_ready_d    = 1'b1;
          frame_done_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        div_cnt_d = '0;
        bit_cnt_d = '0;
        ser_out_d = 1'b1;
        s_ready_d = 1'b1;
        busy_d    = 1'b0;
      end
    endcase
  end

  // State registers; reset drops any frame in flight and returns to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      // NOTE: the shift register is ordinary flops, not a memory, so it is
      // reset along with everything else to keep the idle state deterministic.
      shift_q      <= '0;
      parity_q     <= 1'b0;
      ser_out_q    <= 1'b1;
      s_ready_q    <= 1'b1;
      shift_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      ser_out_q    <= ser_out_d;
      s_ready_q    <= s_ready_d;
      shift_en_q   <= shift_en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign ser_out    = ser_out_q;
  assign shift_en   = shift_en_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx. Two instances: A (8-bit, DIV=2, parity) and
// B (16-bit, DIV=1, no parity). A frame-level model predicts every output on
// every cycle; directed tests add literal bitstream expectations.
module tb_serial_frame_tx;

  localparam int A_DW  = 8;
  localparam int A_DIV = 2;
  localparam bit A_PE  = 1'b1;
  localparam int B_DW  = 16;
  localparam int B_DIV = 1;
  localparam bit B_PE  = 1'b0;

  typedef struct packed {
    logic ser;
    logic sen;
    logic busy;
    logic ready;
    logic done;
  } exp_t;

  localparam exp_t IDLE_REC = '{ser: 1'b1, sen: 1'b0, busy: 1'b0, ready: 1'b1, done: 1'b0};
  localparam exp_t DONE_REC = '{ser: 1'b1, sen: 1'b0, busy: 1'b0, ready: 1'b1, done: 1'b1};

  logic clk = 1'b0;
  logic rst_n_a, rst_n_b;
  logic [A_DW-1:0] s_data_a;
  logic [B_DW-1:0] s_data_b;
  logic s_valid_a, s_valid_b;
  logic s_ready_a, ser_out_a, shift_en_a, busy_a, frame_done_a;
  logic s_ready_b, ser_out_b, shift_en_b, busy_b, frame_done_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_frame_tx #(.DATA_W(A_DW), .DIV(A_DIV), .PARITY_EN(A_PE)) u_dut_a (
    .clk(clk), .rst_n(rst_n_a), .s_data(s_data_a), .s_valid(s_valid_a),
    .s_ready(s_ready_a), .ser_out(ser_out_a), .shift_en(shift_en_a),
    .busy(busy_a), .frame_done(frame_done_a)
  );

  serial_frame_tx #(.DATA_W(B_DW), .DIV(B_DIV), .PARITY_EN(B_PE)) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .s_data(s_data_b), .s_valid(s_valid_b),
    .s_ready(s_ready_b), .ser_out(ser_out_b), .shift_en(shift_en_b),
    .busy(busy_b), .frame_done(frame_done_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Bit list of a frame in transmit order: start, data MSB-first, parity, stop.
  function automatic int build_bits(input logic [31:0] w, input int dw, input bit pe,
                                    output logic [63:0] seq);
    int  n;
    logic p;
    seq = '0;
    p   = 1'b0;
    n   = 1;
    for (int i = dw - 1; i >= 0; i--) begin
      seq[n] = w[i];
      p      = p ^ w[i];
      n++;
    end
    if (pe) begin
      seq[n] = p;
      n++;
    end
    seq[n] = 1'b1;
    n++;
    return n;
  endfunction

  // Model: queue of expected per-cycle outputs for the frame in flight.
  exp_t mq_a[$];
  exp_t mq_b[$];

  always @(posedge clk) begin
    exp_t cur, rec;
    logic [63:0] seq;
    int n;
    cur = (mq_a.size() > 0) ? mq_a[0] : IDLE_REC;
    if (!rst_n_a) begin
      mq_a.delete();
    end else begin
      if (mq_a.size() > 0) void'(mq_a.pop_front());
      if (s_valid_a && cur.ready) begin
        n = build_bits({24'd0, s_data_a}, A_DW, A_PE, seq);
        for (int b = 0; b < n; b++) begin
          for (int k = 0; k < A_DIV; k++) begin
            rec = '{ser: seq[b], sen: (k == 0), busy: 1'b1, ready: 1'b0, done: 1'b0};
            mq_a.push_back(rec);
          end
        end
        mq_a.push_back(DONE_REC);
      end
    end
  end

  always @(posedge clk) begin
    exp_t cur, rec;
    logic [63:0] seq;
    int n;
    cur = (mq_b.size() > 0) ? mq_b[0] : IDLE_REC;
    if (!rst_n_b) begin
      mq_b.delete();
    end else begin
      if (mq_b.size() > 0) void'(mq_b.pop_front());
      if (s_valid_b && cur.ready) begin
        n = build_bits({16'd0, s_data_b}, B_DW, B_PE, seq);
        for (int b = 0; b < n; b++) begin
          for (int k = 0; k < B_DIV; k++) begin
            rec = '{ser: seq[b], sen: (k == 0), busy: 1'b1, ready: 1'b0, done: 1'b0};
            mq_b.push_back(rec);
          end
        end
        mq_b.push_back(DONE_REC);
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    exp_t ea, eb;
    ea = (!rst_n_a || mq_a.size() == 0) ? IDLE_REC : mq_a[0];
    eb = (!rst_n_b || mq_b.size() == 0) ? IDLE_REC : mq_b[0];
    check("a_ser_out",    ser_out_a,    ea.ser);
    check("a_shift_en",   shift_en_a,   ea.sen);
    check("a_busy",       busy_a,       ea.busy);
    check("a_s_ready",    s_ready_a,    ea.ready);
    check("a_frame_done", frame_done_a, ea.done);
    check("b_ser_out",    ser_out_b,    eb.ser);
    check("b_shift_en",   shift_en_b,   eb.sen);
    check("b_busy",       busy_b,       eb.busy);
    check("b_s_ready",    s_ready_b,    eb.ready);
    check("b_frame_done", frame_done_b, eb.done);
  end

  function automatic logic ser_of(input bit inst);
    return inst ? ser_out_b : ser_out_a;
  endfunction
  function automatic logic sen_of(input bit inst);
    return inst ? shift_en_b : shift_en_a;
  endfunction
  function automatic logic done_of(input bit inst);
    return inst ? frame_done_b : frame_done_a;
  endfunction

  // One-cycle s_valid pulse; returns just after the accepting edge.
  task automatic send(input bit inst, input logic [31:0] w);
    @(posedge clk); #2;
    if (inst) begin s_valid_b = 1'b1; s_data_b = w[15:0]; end
    else      begin s_valid_a = 1'b1; s_data_a = w[7:0];  end
    @(posedge clk); #2;
    if (inst) s_valid_b = 1'b0;
    else      s_valid_a = 1'b0;
  endtask

  // Record n cycles of ser_out from the start bit on (first cycle lands in the
  // MSB of seq), count shift_en strobes, and locate frame_done relative to it.
  task automatic capture(input bit inst, input int n, output logic [63:0] seq,
                         output int sen_cnt, output int done_at);
    int waited;
    seq     = '0;
    sen_cnt = 0;
    done_at = -1;
    waited  = 0;
    @(negedge clk);
    while (ser_of(inst) !== 1'b0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("start_seen", ser_of(inst), 1'b0);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      seq = {seq[62:0], ser_of(inst)};
      if (sen_of(inst)) sen_cnt++;
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (done_of(inst) && done_at < 0) done_at = n + j;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] seq;
    int sen_cnt, done_at, cnt, iter;

    rst_n_a = 1'b0; rst_n_b = 1'b0;
    s_valid_a = 1'b0; s_valid_b = 1'b0;
    s_data_a = '0; s_data_b = '0;

    // Reset state.
    @(negedge clk);
    check("rst_ser_out",    ser_out_a,    1'b1);
    check("rst_s_ready",    s_ready_a,    1'b1);
    check("rst_shift_en",   shift_en_a,   1'b0);
    check("rst_busy",       busy_a,       1'b0);
    check("rst_frame_done", frame_done_a, 1'b0);
    @(posedge clk); #2;
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    repeat (2) @(posedge clk);

    // 1: 0xA5, even parity 0.
    send(0, 32'hA5);
    capture(0, 22, seq, sen_cnt, done_at);
    check("t1_bits", seq[21:0], 22'b0011001100001100110011);
    check("t1_shift_en_cnt", sen_cnt, 11);
    check("t1_done_at", done_at, 22);

    // 2: 0x01, parity bit 1.
    send(0, 32'h01);
    capture(0, 22, seq, sen_cnt, done_at);
    check("t2_bits", seq[21:0], 22'b0000000000000000111111);
    check("t2_parity_bit", seq[3], 1'b1);
    check("t2_shift_en_cnt", sen_cnt, 11);

    // 3: back-to-back with s_valid held high.
    @(posedge clk); #2;
    s_valid_a = 1'b1; s_data_a = 8'h3C;
    @(posedge clk); #2;
    s_data_a = 8'h81;
    cnt = 0;
    iter = 0;
    while (iter < 40) begin
      @(negedge clk);
      iter++;
      if (frame_done_a) break;
      if (s_ready_a) cnt++;
    end
    check("t3_ready_low_in_frame", cnt, 0);
    check("t3_done_seen", frame_done_a, 1'b1);
    check("t3_done_latency", iter, 23);
    check("t3_ready_on_done", s_ready_a, 1'b1);
    @(posedge clk); #2;
    s_valid_a = 1'b0;
    @(negedge clk);
    check("t3_next_start", ser_out_a, 1'b0);
    check("t3_next_shift_en", shift_en_a, 1'b1);
    repeat (30) @(posedge clk);

    // 4: stray s_valid mid-frame is ignored.
    send(0, 32'hC3);
    fork
      capture(0, 22, seq, sen_cnt, done_at);
      begin
        repeat (6) @(posedge clk); #2;
        s_valid_a = 1'b1; s_data_a = 8'hFF;
        @(posedge clk); #2;
        s_valid_a = 1'b0;
      end
    join
    check("t4_bits", seq[21:0], 22'b0011110000000011110011);
    check("t4_done_at", done_at, 22);
    repeat (3) @(posedge clk);
    check("t4_idle_after", busy_a, 1'b0);

    // 5: reset during DATA bit 3.
    send(0, 32'h5A);
    repeat (8) @(posedge clk); #2;
    rst_n_a = 1'b0;
    @(negedge clk);
    check("t5_rst_ser_out",  ser_out_a,  1'b1);
    check("t5_rst_busy",     busy_a,     1'b0);
    check("t5_rst_s_ready",  s_ready_a,  1'b1);
    check("t5_rst_shift_en", shift_en_a, 1'b0);
    repeat (2) @(posedge clk); #2;
    rst_n_a = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (frame_done_a) cnt++;
    end
    check("t5_no_frame_done", cnt, 0);
    send(0, 32'h96);
    capture(0, 22, seq, sen_cnt, done_at);
    check("t5_bits", seq[21:0], 22'b0011000011001111000011);
    check("t5_done_at", done_at, 22);

    // 6: DIV=1, no parity, 16-bit.
    send(1, 32'h8001);
    capture(1, 18, seq, sen_cnt, done_at);
    check("t6_bits", seq[17:0], 18'b010000000000000011);
    check("t6_shift_en_cnt", sen_cnt, 18);
    check("t6_done_at", done_at, 18);

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
Upstream feeder for the serial shift chain (three-flop synchronizer followed by the IIC wrapper). Accepts parallel words over a valid/ready handshake and serializes each one into a framed bitstream on ser_out: start bit, data MSB-first, optional even parity, stop bit. Emits a one-cycle shift_en strobe at every bit boundary, which drives the downstream shift-register enable. All logic is in the single clk domain.

Parameters:
DATA_W, 16, payload width in bits (legal range 1..32).
DIV, 4, clk cycles each bit is held on ser_out (must be >= 1; elaboration error otherwise).
PARITY_EN, 1, 1 inserts an even-parity bit after the data; 0 omits it.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
rst_n  in  1  asynchronous active-low reset; release is synchronous to clk.
s_data  in  DATA_W  parallel word to send.
s_valid  in  1  s_data is valid.
s_ready  out  1  block can accept a word; registered.
ser_out  out  1  serial line; idle level is 1; registered.
shift_en  out  1  one-cycle strobe on the first cycle of every bit, including start and stop.
busy  out  1  high from the cycle after acceptance through the last stop-bit cycle.
frame_done  out  1  one-cycle pulse on the cycle after the stop bit ends.

Behaviour:
- Reset values (asserted asynchronously): ser_out=1, s_ready=1, shift_en=0, busy=0, frame_done=0, FSM=IDLE, all counters 0, shift register 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: s_ready=1, ser_out=1.
  - A transfer is accepted on an edge where s_valid && s_ready.
  - On that edge: latch s_data into the shift register; compute parity = XOR of s_data; go to START; s_ready<=0, busy<=1, ser_out<=0, shift_en<=1.
- Bit timing:
  - A divider counter counts 0..DIV-1 within each bit. The bit changes when the count reaches DIV-1.
  - shift_en is high only in the cycle where a new bit value first appears on ser_out.
  - With DIV=1, shift_en stays high for the whole frame.
- START: hold 0 for DIV cycles, then go to DATA and present s_data[DATA_W-1].
- DATA:
  - Shift MSB-first; a bit counter counts 0..DATA_W-1.
  - After the LSB's DIV cycles, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: drive the even-parity bit (the XOR of the data) for DIV cycles, then go to STOP.
- STOP: drive 1 for DIV cycles. On the final STOP cycle's edge: go to IDLE; busy<=0, s_ready<=1, frame_done<=1 for one cycle.
- Frame length in clk cycles = DIV*(DATA_W+PARITY_EN+2).
- Latency: the start bit appears on ser_out in the cycle after the accepting edge.
- Back-to-back: s_ready rises in the same cycle frame_done pulses. If s_valid is already high, the next word is accepted at that edge. The next start bit then follows the stop bit directly, with one idle-high cycle between them (the IDLE cycle).
- While busy, s_ready=0. s_valid and s_data are ignored and need not be held stable; the latched copy is used.
- Reset mid-frame: outputs return to reset values immediately. The frame in flight is dropped, with no frame_done. After rst_n deasserts, the block is ready the next cycle.
- Counter widths: $clog2(DIV) and $clog2(DATA_W), each with a minimum of 1 bit. Counters never wrap past their terminal value.

Test Plan:
1. DATA_W=8, DIV=2, PARITY_EN=1; send 0xA5 with one s_valid pulse. Expect ser_out, in 2-cycle bits: 0, 1,0,1,0,0,1,0,1, 0 (parity), 1. That is 22 cycles. Expect 11 shift_en pulses, 2 cycles apart, and frame_done exactly 22 cycles after the start bit first appears.
2. Same configuration; send 0x01. Expect parity bit = 1 and a total of 11 bits.
3. Hold s_valid high with 0x3C then 0x81 queued. Expect s_ready=0 throughout frame 1. Expect 0x81 accepted on the frame_done cycle, with its start bit one cycle later.
4. Pulse s_valid with a different word mid-frame. Expect no acceptance, and the frame-1 bitstream unchanged.
5. Assert rst_n=0 during DATA bit 3. Expect ser_out=1, busy=0, s_ready=1 in the same cycle, and no frame_done. After release, a new word transmits correctly.
6. DATA_W=16, DIV=1, PARITY_EN=0; send 0x8001. Expect an 18-cycle frame: 0,1,0×14,1,1. Expect shift_en high for all 18 cycles, then frame_done.
